// File: rtl/intersection_sched_if.sv
// Interface bundling the tick/sensor inputs and lamp/debug outputs of intersection_sched.
// With TL_NIGHT_FLASH_EN defined it also carries the night-mode request.
interface intersection_sched_if;
  logic       tick_1hz;
  logic       car_ew;
  logic       ped_req;
`ifdef TL_NIGHT_FLASH_EN
  logic       night;
`endif
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic [3:0] sec_out;
  logic [2:0] phase;

`ifdef TL_NIGHT_FLASH_EN
  modport master (output tick_1hz, car_ew, ped_req, night,
                  input  ns_light, ew_light, walk, sec_out, phase);
  modport slave  (input  tick_1hz, car_ew, ped_req, night,
                  output ns_light, ew_light, walk, sec_out, phase);
`else
  modport master (output tick_1hz, car_ew, ped_req,
                  input  ns_light, ew_light, walk, sec_out, phase);
  modport slave  (input  tick_1hz, car_ew, ped_req,
                  output ns_light, ew_light, walk, sec_out, phase);
`endif
endinterface

// File: rtl/intersection_sched.sv
// Demand-driven two-road phase scheduler with pedestrian WALK; NS rests in green.
// Defining TL_NIGHT_FLASH_EN adds a night input and the flashing-yellow FLASH phase.
module intersection_sched #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  intersection_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [3:0] ALLRED_LD = 4'(ALLRED_T - 1);
  localparam logic [3:0] YELLOW_LD = 4'(YELLOW_T - 1);
  localparam logic [3:0] WALK_LD   = 4'(WALK_T - 1);
  localparam logic [4:0] MIN_E     = 5'(GREEN_MIN);
  localparam logic [4:0] MAX_E     = 5'(GREEN_MAX);

  localparam logic [1:0] L_OFF    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_RED    = 2'b11;

  state_t     state, state_d;
  logic       nxt, nxt_d;
  logic [3:0] timer, timer_d;
  logic [3:0] elapsed, elapsed_d;
  logic       ew_pend, ew_pend_d;
  logic       ped_pend, ped_pend_d;
  logic       flash_on, flash_on_d;
  logic [4:0] e;
  logic       night_in;

  logic [1:0] ns_light_r, ew_light_r;
  logic       walk_r;
  logic [3:0] sec_r;
  logic [2:0] phase_r;

`ifdef TL_NIGHT_FLASH_EN
  assign night_in = bus.night;
`else
  assign night_in = 1'b0;
`endif

  function automatic logic [1:0] road_light(state_t s, state_t g, state_t y, logic fl);
    if (s == g)          return L_GREEN;
    else if (s == y)     return L_YELLOW;
    else if (s == FLASH) return fl ? L_YELLOW : L_OFF;
    else                 return L_RED;
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sec_value(state_t s, logic [3:0] tmr, logic [3:0] el);
    case (s)
      NS_GREEN, EW_GREEN: return el;
      FLASH:              return 4'd0;
      default:            return tmr;
    endcase
  endfunction

  // Green exit thresholds count the tick being processed.
  assign e = {1'b0, elapsed} + 5'd1;

  always_comb begin
    state_d    = state;
    nxt_d      = nxt;
    timer_d    = timer;
    elapsed_d  = elapsed;
    flash_on_d = flash_on;
    if (bus.tick_1hz) begin
      case (state)
        ALL_RED: begin
          if (timer != 4'd0) begin
            timer_d = timer - 4'd1;
          end else if (night_in) begin
            state_d    = FLASH;
            flash_on_d = 1'b1;
          end else if (ped_pend) begin
            state_d = WALK;
            timer_d = WALK_LD;
          end else if (nxt && ew_pend) begin
            state_d   = EW_GREEN;
            elapsed_d = 4'd0;
          end else begin
            state_d   = NS_GREEN;
            elapsed_d = 4'd0;
          end
        end
        NS_GREEN: begin
          if (e >= MIN_E && (ew_pend || ped_pend)) begin
            state_d = NS_YELLOW;
            timer_d = YELLOW_LD;
          end else begin
            elapsed_d = sat_inc(elapsed);
          end
        end
        EW_GREEN: begin
          if (e >= MAX_E || (e >= MIN_E && (!bus.car_ew || ped_pend))) begin
            state_d = EW_YELLOW;
            timer_d = YELLOW_LD;
          end else begin
            elapsed_d = sat_inc(elapsed);
          end
        end
        NS_YELLOW, EW_YELLOW, WALK: begin
          if (timer != 4'd0) begin
            timer_d = timer - 4'd1;
          end else begin
            state_d = ALL_RED;
            timer_d = ALLRED_LD;
            if (state == NS_YELLOW)      nxt_d = 1'b1;
            else if (state == EW_YELLOW) nxt_d = 1'b0;
          end
        end
        FLASH: begin
          if (!night_in) begin
            state_d = ALL_RED;
            nxt_d   = 1'b0;
            timer_d = ALLRED_LD;
          end else begin
            flash_on_d = ~flash_on;
          end
        end
        default: begin
          state_d = ALL_RED;
          timer_d = ALLRED_LD;
        end
      endcase
    end
  end

  // Demand latches collect every cycle; clearing on phase entry wins over a same-cycle set.
  always_comb begin
    ew_pend_d  = ew_pend | (bus.car_ew & (state != EW_GREEN));
    ped_pend_d = ped_pend | (bus.ped_req & (state != WALK));
    if (state_d == EW_GREEN && state != EW_GREEN) ew_pend_d = 1'b0;
    if (state_d == WALK && state != WALK)         ped_pend_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALL_RED;
      nxt      <= 1'b0;
      timer    <= ALLRED_LD;
      elapsed  <= 4'd0;
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
      flash_on <= 1'b0;
    end else begin
      state    <= state_d;
      nxt      <= nxt_d;
      timer    <= timer_d;
      elapsed  <= elapsed_d;
      ew_pend  <= ew_pend_d;
      ped_pend <= ped_pend_d;
      flash_on <= flash_on_d;
    end
  end

  // Output stage: lamps and debug lag the phase registers by one cycle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ns_light_r <= L_RED;
      ew_light_r <= L_RED;
      walk_r     <= 1'b0;
      sec_r      <= ALLRED_LD;
      phase_r    <= 3'd0;
    end else begin
      ns_light_r <= road_light(state, NS_GREEN, NS_YELLOW, flash_on);
      ew_light_r <= road_light(state, EW_GREEN, EW_YELLOW, flash_on);
      walk_r     <= (state == WALK);
      sec_r      <= sec_value(state, timer, elapsed);
      phase_r    <= state;
    end
  end

  assign bus.ns_light = ns_light_r;
  assign bus.ew_light = ew_light_r;
  assign bus.walk     = walk_r;
  assign bus.sec_out  = sec_r;
  assign bus.phase    = phase_r;

endmodule

// File: tb/tb_intersection_sched.sv
// Randomized and directed bench for intersection_sched against a tick-counting phase model.
module tb_intersection_sched;
  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 10;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  intersection_sched_if bus ();

  intersection_sched #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .CLOCK_50(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: phase number plus ticks spent in it; timers and elapsed are derived.
  int m_ph, m_ticks;
  bit m_nxt, m_ewp, m_pedp, m_flash;
  int exp_ns, exp_ew, exp_walk, exp_sec, exp_ph;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      0:       return ALLRED_T;
      2, 4:    return YELLOW_T;
      5:       return WALK_T;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ticks = 0; m_nxt = 0; m_ewp = 0; m_pedp = 0; m_flash = 0;
  endtask

  task automatic model_step(input bit t, input bit c, input bit p, input bit n);
    int  np;
    int  e;
    bit  done;
    exp_ph   = m_ph;
    exp_ns   = (m_ph == 1) ? 1 : (m_ph == 2) ? 2 : (m_ph == 6) ? (m_flash ? 2 : 0) : 3;
    exp_ew   = (m_ph == 3) ? 1 : (m_ph == 4) ? 2 : (m_ph == 6) ? (m_flash ? 2 : 0) : 3;
    exp_walk = (m_ph == 5) ? 1 : 0;
    if (m_ph == 1 || m_ph == 3) exp_sec = (m_ticks > 15) ? 15 : m_ticks;
    else if (m_ph == 6)         exp_sec = 0;
    else                        exp_sec = dur(m_ph) - 1 - m_ticks;
    np = m_ph;
    if (t) begin
      e    = m_ticks + 1;
      done = (m_ticks == dur(m_ph) - 1);
      case (m_ph)
        0: if (done) np = n ? 6 : m_pedp ? 5 : (m_nxt && m_ewp) ? 3 : 1;
        1: if (e >= GREEN_MIN && (m_ewp || m_pedp)) np = 2;
        2: if (done) begin np = 0; m_nxt = 1; end
        3: if (e >= GREEN_MAX || (e >= GREEN_MIN && (!c || m_pedp))) np = 4;
        4: if (done) begin np = 0; m_nxt = 0; end
        5: if (done) np = 0;
        6: if (!n) begin np = 0; m_nxt = 0; end else m_flash = !m_flash;
        default: np = 0;
      endcase
    end
    m_ewp  = (np == 3 && m_ph != 3) ? 1'b0 : (m_ewp || (c && m_ph != 3));
    m_pedp = (np == 5 && m_ph != 5) ? 1'b0 : (m_pedp || (p && m_ph != 5));
    if (np != m_ph) begin
      m_ticks = 0;
      if (np == 6) m_flash = 1;
    end else if (t && m_ph != 6) begin
      m_ticks++;
    end
    m_ph = np;
  endtask

  task automatic drive(input bit t, input bit c, input bit p, input bit n);
    bus.tick_1hz = t;
    bus.car_ew   = c;
    bus.ped_req  = p;
`ifdef TL_NIGHT_FLASH_EN
    bus.night    = n;
`endif
  endtask

  task automatic cyc(input bit t, input bit c, input bit p, input bit n);
    @(negedge clk);
    drive(t, c, p, n);
`ifdef TL_NIGHT_FLASH_EN
    model_step(t, c, p, n);
`else
    model_step(t, c, p, 1'b0);
`endif
  endtask

  task automatic ticks(input int cnt, input bit c, input bit p, input bit n);
    for (int i = 0; i < cnt; i++) begin
      cyc(1'b1, c, p, n);
      for (int j = 0; j < 3; j++) cyc(1'b0, c, p, n);
    end
  endtask

  task automatic see(input string nm, input int ph, input int ns, input int ew,
                     input int wk, input int sec);
    chk({nm, ".phase"}, int'(bus.phase), ph);
    chk({nm, ".ns"},    int'(bus.ns_light), ns);
    chk({nm, ".ew"},    int'(bus.ew_light), ew);
    chk({nm, ".walk"},  int'(bus.walk), wk);
    chk({nm, ".sec"},   int'(bus.sec_out), sec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    chk_en = 0;
    #1;
    see("async_reset", 0, 3, 3, 0, ALLRED_T - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1;
  endtask

  // Every-cycle comparison against the model, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en && rst_n) begin
      chk("cyc.phase", int'(bus.phase), exp_ph);
      chk("cyc.ns",    int'(bus.ns_light), exp_ns);
      chk("cyc.ew",    int'(bus.ew_light), exp_ew);
      chk("cyc.walk",  int'(bus.walk), exp_walk);
      chk("cyc.sec",   int'(bus.sec_out), exp_sec);
    end
  end

  initial begin
    bit car, night_r;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    // No demand: NS rests in green, elapsed saturates.
    do_reset();
    ticks(1, 0, 0, 0);  see("first_tick", 1, 1, 3, 0, 0);
    ticks(20, 0, 0, 0); see("ns_rest", 1, 1, 3, 0, 15);

    // Single car pulse at elapsed 2, then EW with no car, async reset in EW_YELLOW.
    do_reset();
    ticks(1, 0, 0, 0);
    ticks(2, 0, 0, 0);  see("ns_el2", 1, 1, 3, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2, 0, 0, 0);  see("ns_el4", 1, 1, 3, 0, 4);
    ticks(1, 0, 0, 0);  see("ns_yel", 2, 2, 3, 0, 2);
    ticks(2, 0, 0, 0);  see("ns_yel_end", 2, 2, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("allred_ew", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("ew_green", 3, 3, 1, 0, 0);
    ticks(4, 0, 0, 0);  see("ew_el4", 3, 3, 1, 0, 4);
    ticks(1, 0, 0, 0);  see("ew_yel", 4, 3, 2, 0, 2);
    do_reset();

    // Car held: EW capped at GREEN_MAX, NS yields again.
    ticks(1, 1, 0, 0);  see("c_ns", 1, 1, 3, 0, 0);
    ticks(5, 1, 0, 0);  see("c_nsy", 2, 2, 3, 0, 2);
    ticks(4, 1, 0, 0);  see("c_ew", 3, 3, 1, 0, 0);
    ticks(9, 1, 0, 0);  see("c_ew9", 3, 3, 1, 0, 9);
    ticks(1, 1, 0, 0);  see("c_ewmax", 4, 3, 2, 0, 2);
    ticks(4, 1, 0, 0);  see("c_ns2", 1, 1, 3, 0, 0);
    ticks(4, 1, 0, 0);  see("c_ns2_el4", 1, 1, 3, 0, 4);
    ticks(1, 1, 0, 0);  see("c_ns2y", 2, 2, 3, 0, 2);

    // Pedestrian at elapsed 7; request during WALK dropped.
    do_reset();
    ticks(1, 0, 0, 0);
    ticks(7, 0, 0, 0);  see("p_el7", 1, 1, 3, 0, 7);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1, 0, 0, 0);  see("p_nsy", 2, 2, 3, 0, 2);
    ticks(3, 0, 0, 0);  see("p_ar", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("p_walk", 5, 3, 3, 1, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5, 0, 0, 0);  see("p_walk_end", 5, 3, 3, 1, 0);
    ticks(1, 0, 0, 0);  see("p_ar2", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("p_ns", 1, 1, 3, 0, 0);
    ticks(6, 0, 0, 0);  see("p_no_rewalk", 1, 1, 3, 0, 6);

    // Pedestrian and car together: WALK precedes EW.
    do_reset();
    ticks(1, 0, 0, 0);
    ticks(5, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(1, 0, 0, 0);  see("pc_nsy", 2, 2, 3, 0, 2);
    ticks(3, 0, 0, 0);  see("pc_ar", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("pc_walk", 5, 3, 3, 1, 5);
    ticks(6, 0, 0, 0);  see("pc_ar2", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("pc_ew", 3, 3, 1, 0, 0);

`ifdef TL_NIGHT_FLASH_EN
    do_reset();
    ticks(1, 0, 0, 1);  see("n_flash_on", 6, 2, 2, 0, 0);
    ticks(1, 0, 0, 1);  see("n_flash_off", 6, 0, 0, 0, 0);
    ticks(1, 0, 0, 1);  see("n_flash_on2", 6, 2, 2, 0, 0);
    ticks(1, 0, 0, 0);  see("n_ar", 0, 3, 3, 0, 0);
    ticks(1, 0, 0, 0);  see("n_ns", 1, 1, 3, 0, 0);
`endif

    // Random traffic with one mid-run reset.
    do_reset();
    car = 0;
    night_r = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0) car = !car;
`ifdef TL_NIGHT_FLASH_EN
      if ($urandom_range(0, 150) == 0) night_r = !night_r;
`endif
      if (i == 3000) do_reset();
      cyc(($urandom_range(0, 2) == 0), car, ($urandom_range(0, 60) == 0), night_r);
    end

    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intersection_sched.md
Name: intersection_sched

Overview:
- Two-road intersection phase scheduler: arbitrates right-of-way between the main road (NS) and the side road (EW), plus a pedestrian WALK phase.
- Sits between the 1 Hz tick generator and the LED/7-seg drivers, replacing the fixed-cycle light sequencer.
- Fully single-clock: the 1 Hz source is a one-cycle enable pulse, not a derived clock.
- NS rests in green and yields only on demand.

Parameters:
- GREEN_MIN, 5, minimum green ticks for either road (1..15)
- GREEN_MAX, 10, EW green ceiling in ticks (GREEN_MIN..15)
- YELLOW_T, 3, yellow ticks (1..15)
- ALLRED_T, 1, all-red clearance ticks (1..15)
- WALK_T, 6, pedestrian walk ticks (1..15)

Ports:
- CLOCK_50  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle enable pulse, 1 Hz
- car_ew  in  1  EW vehicle sensor, level, synchronous
- ped_req  in  1  pedestrian button pulse/level, synchronous
- ns_light  out  2  00 off, 01 green, 10 yellow, 11 red
- ew_light  out  2  same encoding
- walk  out  1  pedestrian walk lamp
- sec_out  out  4  phase timer value for 7-seg
- phase  out  3  current state code, debug

Behaviour:
- States (codes 0..6): ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, WALK, FLASH. Register `nxt` holds the road to serve after ALL_RED (0 = NS, 1 = EW).
- Reset values:
  - state ALL_RED, nxt NS, timer ALLRED_T-1, elapsed 0.
  - Both pending latches 0.
  - ns_light = ew_light = 11, walk 0, sec_out ALLRED_T-1.
  - All outputs registered, updated the cycle after the state change.
- State and timer registers change only on cycles with tick_1hz = 1. Exceptions: latches and reset.
- Timed phases (ALL_RED, YELLOWs, WALK):
  - timer loaded with T-1 on entry, decremented per tick.
  - On a tick with timer == 0, the phase exits, so each phase lasts exactly T ticks.
  - sec_out = timer.
- Green phases:
  - elapsed cleared on entry, +1 per tick, saturating at 15; sec_out = elapsed.
  - Exit decisions use e = elapsed+1 on the current tick.
- NS_GREEN → NS_YELLOW on a tick when e >= GREEN_MIN and (ew_pend or ped_pend). Otherwise NS_GREEN holds indefinitely.
- EW_GREEN → EW_YELLOW on a tick when e >= GREEN_MAX, or when e >= GREEN_MIN and (car_ew == 0 or ped_pend).
- NS_YELLOW → ALL_RED with nxt = EW. EW_YELLOW → ALL_RED with nxt = NS.
- ALL_RED exit, in priority order:
  1. ped_pend → WALK.
  2. nxt = EW and ew_pend → EW_GREEN.
  3. Otherwise → NS_GREEN.
- WALK → ALL_RED with nxt unchanged. WALK re-entry is blocked because ped_pend was cleared on entry.
- ew_pend:
  - set when car_ew = 1 in any state except EW_GREEN.
  - cleared on the EW_GREEN entry cycle; set-on-same-cycle is ignored.
- ped_pend:
  - set on ped_req = 1 in any state except WALK.
  - cleared on the WALK entry cycle; requests during WALK are dropped.
- Lights:
  - Each road is red unless in its own GREEN/YELLOW phase.
  - walk = 1 only in WALK.
  - Both roads red in WALK.
- Never both roads non-red in the same cycle.
- rst_n assertion mid-phase forces reset values immediately (asynchronous).
- The first tick after reset ends ALL_RED (ALLRED_T = 1) → NS_GREEN.

Optional Feature:
- Macro TL_NIGHT_FLASH_EN.
- Defined:
  - adds input port night (1 bit).
  - If night = 1 when ALL_RED exits on a tick, go to FLASH instead.
  - FLASH: ns_light and ew_light toggle 10↔00 on each tick, starting at 10; walk 0; sec_out 0; latches keep collecting.
  - On a tick with night = 0, FLASH → ALL_RED with nxt = NS and timer ALLRED_T-1.
- Undefined: port absent, FLASH unreachable, code 6 never output.

Test Plan:
- Reset, 1 tick, no demand → phase NS_GREEN, ns 01, ew 11; after 20 more ticks still NS_GREEN, sec_out 15 (saturated).
- car_ew pulsed 1 cycle at NS_GREEN elapsed 2 → yellow on the 5th green tick, 3 yellow ticks, 1 all-red tick, then EW_GREEN. With car_ew held 0, EW_YELLOW begins on the 5th EW tick.
- car_ew held 1 continuously → EW_GREEN lasts exactly 10 ticks, then EW_YELLOW; ew_pend set again, so NS yields again after 5 green ticks.
- ped_req during NS_GREEN (elapsed 7, no car) → yellow on the next tick, ALL_RED, WALK for 6 ticks with both roads 11 and walk 1, ALL_RED, NS_GREEN. ped_req during WALK → no second WALK.
- ped_req and car_ew together during NS_GREEN → order is NS_YELLOW, ALL_RED, WALK, ALL_RED, EW_GREEN.
- rst_n low mid-EW_YELLOW → within the same cycle both lights 11, phase 0, walk 0. With TL_NIGHT_FLASH_EN, night = 1 → after ALL_RED the lights alternate 10/00 per tick; night = 0 → ALL_RED, then NS_GREEN.
